ahb_region_mux: RTL
===================

Name: ahb_region_mux

Overview:
- Parametrised AHB-Lite address decoder plus slave multiplexer for the DSP subsystem register fabric.
- Replaces the fixed 16-bit-region decode and the 10-port slave mux with a single block. It takes an N-port count, a configurable region size and a base region.
- Adds three behaviours the fixed mux lacks:
  - a built-in default slave returning a two-cycle ERROR for unmapped addresses;
  - a per-port wait-state watchdog;
  - sticky fault isolation of hung slaves.
- Sits between the AHB sync bridge master side and the DSP module slaves (AGC, CIC, FFT window, etc.).

Parameters:
- NPORT, 7, number of slave ports (1..16).
- AW, 32, address width.
- DW, 32, data width.
- REGION_BITS, 16, region select is haddr_s[AW-1:REGION_BITS].
- BASE_REGION, 0, region index mapped to port 0.
- TIMEOUT, 256, wait-state cycles before watchdog fires (0 = watchdog disabled).

Ports:
- hclk  in  1  clock.
- hreset  in  1  synchronous active-high reset.
- hsel_s  in  1  block select from upstream.
- haddr_s  in  AW  address phase address.
- htrans_s  in  2  transfer type.
- hready_s  in  1  bus HREADY (tie to hreadyout_s when there is no cascade).
- hrdata_s  out  DW  read data to master.
- hreadyout_s  out  1  ready to master.
- hresp_s  out  1  response to master (1 = ERROR).
- hsel_m  out  NPORT  one-hot slave selects, combinational.
- hrdata_m  in  NPORT*DW  slave read data, port k at bits [k*DW +: DW].
- hreadyout_m  in  NPORT  slave ready.
- hresp_m  in  NPORT  slave response.
- fault  out  NPORT  sticky per-port hung-slave flags.
- fault_clr  in  NPORT  per-port fault clear, single-cycle pulse.
- timeout_irq  out  1  one-cycle pulse when the watchdog fires.
- timeout_port  out  4  index of the last port that timed out.

Behaviour:
- Decode (combinational):
  - idx = haddr_s[AW-1:REGION_BITS] - BASE_REGION.
  - hit = hsel_s & (idx < NPORT) & !fault[idx].
  - hsel_m[idx] = hit; all other bits are 0. htrans_s does not gate hsel_m (AHB rule).
- Data-phase register, updated only when hready_s=1:
  - dp_sel <= one-hot of hit.
  - dp_def <= hsel_s & htrans_s[1] & !hit. This covers unmapped addresses and faulted ports.
  - When hready_s=0, both hold their value.
- Output mux:
  - dp_sel nonzero: outputs pass through hrdata_m/hreadyout_m/hresp_m of the selected port, unless the watchdog overrides.
  - Neither dp_sel nor dp_def set: hrdata_s=0, hreadyout_s=1, hresp_s=0 (IDLE/BUSY or deselected returns zero-wait OKAY).
- Response FSM states: IDLE, ERR1, ERR2.
  - IDLE -> ERR1 when hready_s=1 and the next dp_def=1.
  - ERR1 drives hreadyout_s=0, hresp_s=1, then -> ERR2.
  - ERR2 drives hreadyout_s=1, hresp_s=1, then -> IDLE. It goes directly to ERR1 again if another unmapped NONSEQ/SEQ is accepted in the same cycle.
  - hrdata_s=0 in ERR1 and ERR2.
- Watchdog:
  - wcnt clears whenever hready_s=1 or dp_sel=0.
  - Otherwise wcnt increments each cycle in which the selected slave's hreadyout_m=0.
  - When wcnt reaches TIMEOUT-1 (TIMEOUT>0), on the next edge:
    - FSM -> ERR1;
    - fault[dp_idx] <= 1;
    - timeout_irq pulses 1 cycle;
    - timeout_port <= dp_idx;
    - dp_sel <= 0.
  - From there the standard two-cycle ERROR completes the stalled transfer.
- Fault handling:
  - A faulted port's hsel_m stays 0; accesses to it take the default-slave ERROR path.
  - fault_clr[k]=1 clears fault[k] on the next edge.
  - If set and clear coincide on the same port, set wins.
- Widths: wcnt is clog2(TIMEOUT+1) bits and saturates. idx is computed on AW-REGION_BITS bits; addresses below BASE_REGION wrap to large values and therefore miss.
- Reset (synchronous, any cycle, including mid-transfer or mid-ERROR):
  - dp_sel=0, dp_def=0, FSM=IDLE, wcnt=0, fault=0, timeout_irq=0, timeout_port=0.
  - Outputs are then hreadyout_s=1, hresp_s=0, hrdata_s=0.
- Latency: zero added wait states on mapped paths. Default slave always takes exactly 2 cycles. Watchdog ERROR completes TIMEOUT+2 cycles after the data phase starts.

Test Plan:
- Defaults: NONSEQ read to 0x0003_0010, slave 3 returns 0xDEADBEEF with 0 waits -> hsel_m=0x08 in address phase; next cycle hrdata_s=0xDEADBEEF, hreadyout_s=1, hresp_s=0.
- NONSEQ to 0x0009_0000 (unmapped) -> hsel_m=0; data phase gives ERR1 (ready=0, resp=1) then ERR2 (ready=1, resp=1). IDLE to the same address -> single-cycle OKAY.
- TIMEOUT=8, slave 2 holds hreadyout_m=0 -> after 8 wait cycles timeout_irq pulses, fault=0x04, timeout_port=2, two-cycle ERROR follows. Next access to 0x0002_xxxx -> ERROR with hsel_m=0. After fault_clr[2] pulse, access succeeds.
- Back-to-back NONSEQ: unmapped then mapped slave 1 with 2 wait states -> ERR1, ERR2 (slave 1 address accepted), then ready=0 x2, then OKAY with slave 1 data.
- Assert hreset during ERR1 and during the watchdog count at wcnt=5 -> next cycle hreadyout_s=1, hresp_s=0, fault=0, timeout_irq never pulses.
- NPORT=3, BASE_REGION=4, REGION_BITS=12: address 0x0000_6000 -> hsel_m=0b100. Addresses 0x0000_3000 and 0x0000_7000 -> default ERROR.

Source files
------------

// File: rtl/ahb_region_mux_if.sv
// Bus bundle for ahb_region_mux: upstream AHB-Lite master side, downstream slave ports,
// fault/watchdog status and FSM debug view.
interface ahb_region_mux_if #(
    parameter int NPORT = 7,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    logic                hsel_s;
    logic [AW-1:0]       haddr_s;
    logic [1:0]          htrans_s;
    logic                hready_s;
    logic [DW-1:0]       hrdata_s;
    logic                hreadyout_s;
    logic                hresp_s;
    logic [NPORT-1:0]    hsel_m;
    logic [NPORT*DW-1:0] hrdata_m;
    logic [NPORT-1:0]    hreadyout_m;
    logic [NPORT-1:0]    hresp_m;
    logic [NPORT-1:0]    fault;
    logic [NPORT-1:0]    fault_clr;
    logic                timeout_irq;
    logic [3:0]          timeout_port;
    logic [1:0]          dbg_state;
    logic                dbg_dp_def;

    // Handshake: an address phase is taken on an edge with hready_s=1 (a transfer when also
    // hsel_s & htrans_s[1]); a data phase ends on the edge where hreadyout_s=1.
    modport slave (
        input  hsel_s, haddr_s, htrans_s, hready_s, hrdata_m, hreadyout_m, hresp_m, fault_clr,
        output hrdata_s, hreadyout_s, hresp_s, hsel_m, fault, timeout_irq, timeout_port,
               dbg_state, dbg_dp_def
    );

    modport master (
        output hsel_s, haddr_s, htrans_s, hready_s, hrdata_m, hreadyout_m, hresp_m, fault_clr,
        input  hrdata_s, hreadyout_s, hresp_s, hsel_m, fault, timeout_irq, timeout_port,
               dbg_state, dbg_dp_def
    );
endinterface

// File: rtl/ahb_region_mux.sv
// AHB-Lite region decoder and slave multiplexer with a built-in ERROR default slave,
// per-transfer wait-state watchdog and sticky isolation of hung slave ports.
module ahb_region_mux #(
    parameter int NPORT       = 7,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int REGION_BITS = 16,
    parameter int BASE_REGION = 0,
    parameter int TIMEOUT     = 256
) (
    input logic             hclk,
    input logic             hreset,
    ahb_region_mux_if.slave bus
);
    localparam int IW = AW - REGION_BITS;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit WDOG_EN = (TIMEOUT > 0);
    localparam logic [CW-1:0] WCNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] WCNT_FIRE = WDOG_EN ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ERR1 = 2'd1,
        S_ERR2 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [NPORT-1:0] dp_sel_q, dp_sel_d;
    logic             dp_def_q, dp_def_d;
    logic [CW-1:0]    wcnt_q, wcnt_d;
    logic [NPORT-1:0] fault_q, fault_d;
    logic             irq_q, irq_d;
    logic [3:0]       tport_q, tport_d;

    logic [IW-1:0]    idx;
    logic [NPORT-1:0] hit_vec;
    logic             hit;
    logic             def_next;
    logic [DW-1:0]    sel_rdata;
    logic             sel_ready;
    logic             sel_resp;
    logic [3:0]       dp_idx;
    logic             fire;

    // Region index wraps modulo 2^IW, so regions below BASE_REGION land far out of range.
    assign idx = bus.haddr_s[AW-1:REGION_BITS] - IW'(BASE_REGION);

    always_comb begin
        hit_vec = '0;
        for (int k = 0; k < NPORT; k++) begin
            hit_vec[k] = bus.hsel_s && (idx == IW'(k)) && !fault_q[k];
        end
    end

    assign hit      = |hit_vec;
    assign def_next = bus.hsel_s && bus.htrans_s[1] && !hit;

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        sel_resp  = 1'b0;
        dp_idx    = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (dp_sel_q[k]) begin
                sel_rdata = bus.hrdata_m[k*DW +: DW];
                sel_ready = bus.hreadyout_m[k];
                sel_resp  = bus.hresp_m[k];
                dp_idx    = 4'(k);
            end
        end
    end

    assign fire = WDOG_EN && (|dp_sel_q) && !bus.hready_s && !sel_ready && (wcnt_q == WCNT_FIRE);

    always_comb begin
        dp_sel_d = dp_sel_q;
        dp_def_d = dp_def_q;
        if (bus.hready_s) begin
            dp_sel_d = hit_vec;
            dp_def_d = def_next;
        end
        if (fire) begin
            dp_sel_d = '0;
        end

        wcnt_d = wcnt_q;
        if (bus.hready_s || (dp_sel_q == '0)) begin
            wcnt_d = '0;
        end else if (!sel_ready && (wcnt_q != WCNT_MAX)) begin
            wcnt_d = wcnt_q + 1'b1;
        end

        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = (bus.hready_s && def_next) ? S_ERR1 : S_IDLE;
            S_ERR1:  state_d = S_ERR2;
            S_ERR2:  state_d = (bus.hready_s && def_next) ? S_ERR1 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (fire) begin
            state_d = S_ERR1;
        end

        // A watchdog set beats a coincident clear on the same port.
        fault_d = (fault_q & ~bus.fault_clr) | (fire ? dp_sel_q : '0);
        irq_d   = fire;
        tport_d = fire ? dp_idx : tport_q;
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q  <= S_IDLE;
            dp_sel_q <= '0;
            dp_def_q <= 1'b0;
            wcnt_q   <= '0;
            fault_q  <= '0;
            irq_q    <= 1'b0;
            tport_q  <= '0;
        end else begin
            state_q  <= state_d;
            dp_sel_q <= dp_sel_d;
            dp_def_q <= dp_def_d;
            wcnt_q   <= wcnt_d;
            fault_q  <= fault_d;
            irq_q    <= irq_d;
            tport_q  <= tport_d;
        end
    end

    always_comb begin
        bus.hrdata_s    = '0;
        bus.hreadyout_s = 1'b1;
        bus.hresp_s     = 1'b0;
        if (state_q != S_IDLE) begin
            bus.hreadyout_s = (state_q == S_ERR2);
            bus.hresp_s     = 1'b1;
        end else if (|dp_sel_q) begin
            bus.hrdata_s    = sel_rdata;
            bus.hreadyout_s = sel_ready;
            bus.hresp_s     = sel_resp;
        end
    end

    assign bus.hsel_m       = hit_vec;
    assign bus.fault        = fault_q;
    assign bus.timeout_irq  = irq_q;
    assign bus.timeout_port = tport_q;
    assign bus.dbg_state    = state_q;
    assign bus.dbg_dp_def   = dp_def_q;

endmodule
